// File: rtl/data_mem_ctrl.sv
// Byte-addressable little-endian data memory with RV32I sized loads/stores,
// alignment/range/funct3 error reporting and a fixed wait-state latency.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DEPTH_BYTES = 1048576,
  parameter int unsigned LATENCY     = 0,
  parameter logic [7:0]  INIT_BYTE   = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned     IdxW     = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 2;
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH_BYTES);
  localparam logic [3:0]      LatM1    = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q;

  logic              accept, access;
  logic              acc_write;
  logic [2:0]        acc_f3;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [2:0]        size;
  logic              sext, illegal, misalign, oor, err;
  logic [ADDR_W:0]   last_addr;
  logic [IdxW-1:0]   idx [4];
  logic [7:0]        rbyte [4];

  logic [7:0] mem_q [DEPTH_BYTES] = '{default: INIT_BYTE};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            access  = 1'b1;
            state_d = StResp;
          end else begin
            cnt_d   = LatM1;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Zero-latency accesses happen on the accept edge, before the request is latched.
  always_comb begin
    if (state_q == StIdle) begin
      acc_write = req_write;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_write = write_q;
      acc_f3    = funct3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    size    = 3'd1;
    sext    = 1'b0;
    illegal = 1'b0;
    case (acc_f3)
      3'b000: begin size = 3'd1; sext = 1'b1; end
      3'b001: begin size = 3'd2; sext = 1'b1; end
      3'b010: size = 3'd4;
      3'b100: begin size = 3'd1; illegal = acc_write; end
      3'b101: begin size = 3'd2; illegal = acc_write; end
      default: illegal = 1'b1;
    endcase
    misalign  = ((size == 3'd2) && acc_addr[0]) ||
                ((size == 3'd4) && (acc_addr[1:0] != 2'b00));
    last_addr = {1'b0, acc_addr} + (ADDR_W + 1)'(size) - (ADDR_W + 1)'(1);
    oor       = last_addr >= DepthLim;
    err       = illegal || misalign || oor;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k]   = acc_addr[IdxW-1:0] + IdxW'(k);
      rbyte[k] = mem_q[idx[k]];
    end
    rdata_d = 32'd0;
    if (!err && !acc_write) begin
      case (size)
        3'd1:    rdata_d = {{24{sext & rbyte[0][7]}}, rbyte[0]};
        3'd2:    rdata_d = {{16{sext & rbyte[1][7]}}, rbyte[1], rbyte[0]};
        default: rdata_d = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && access && acc_write && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(size)) mem_q[idx[k]] <= acc_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (access) begin
        rdata_q <= rdata_d;
        err_q   <= err;
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: a zero-latency instance and a three-wait-state instance, 64 bytes each.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_0, req_valid_0, req_ready_0, req_write_0, rsp_valid_0, rsp_ready_0, rsp_err_0;
  logic [2:0]  req_funct3_0;
  logic [7:0]  req_addr_0;
  logic [31:0] req_wdata_0, rsp_rdata_0;
  logic        rst_3, req_valid_3, req_ready_3, req_write_3, rsp_valid_3, rsp_ready_3, rsp_err_3;
  logic [2:0]  req_funct3_3;
  logic [7:0]  req_addr_3;
  logic [31:0] req_wdata_3, rsp_rdata_3;

  int total = 0;
  int bad   = 0;

  data_mem_ctrl #(.ADDR_W(8), .DEPTH_BYTES(64), .LATENCY(0), .INIT_BYTE(8'h00)) dut0 (
    .clk(clk), .reset(rst_0), .req_valid(req_valid_0), .req_ready(req_ready_0),
    .req_write(req_write_0), .req_funct3(req_funct3_0), .req_addr(req_addr_0),
    .req_wdata(req_wdata_0), .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready_0),
    .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0)
  );

  data_mem_ctrl #(.ADDR_W(8), .DEPTH_BYTES(64), .LATENCY(3), .INIT_BYTE(8'h00)) dut3 (
    .clk(clk), .reset(rst_3), .req_valid(req_valid_3), .req_ready(req_ready_3),
    .req_write(req_write_3), .req_funct3(req_funct3_3), .req_addr(req_addr_3),
    .req_wdata(req_wdata_3), .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3),
    .rsp_rdata(rsp_rdata_3), .rsp_err(rsp_err_3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit wr, input logic [2:0] f3,
                       input logic [7:0] addr, input logic [31:0] wd, input bit rr);
    if (sel) begin
      req_valid_3 = 1'b1; req_write_3 = wr; req_funct3_3 = f3;
      req_addr_3 = addr; req_wdata_3 = wd; rsp_ready_3 = rr;
    end else begin
      req_valid_0 = 1'b1; req_write_0 = wr; req_funct3_0 = f3;
      req_addr_0 = addr; req_wdata_0 = wd; rsp_ready_0 = rr;
    end
  endtask

  // Drop valid and scramble the request fields; they must be ignored after accept.
  task automatic scramble(input bit sel);
    if (sel) begin
      req_valid_3 = 1'b0; req_write_3 = 1'b1; req_funct3_3 = 3'b010;
      req_addr_3 = 8'h3C; req_wdata_3 = 32'hFFFF_FFFF;
    end else begin
      req_valid_0 = 1'b0; req_write_0 = 1'b1; req_funct3_0 = 3'b010;
      req_addr_0 = 8'h3C; req_wdata_0 = 32'hFFFF_FFFF;
    end
  endtask

  // One full transaction with rsp_ready held high; lat = cycles from accept to rsp_valid.
  task automatic txn(input bit sel, input bit wr, input logic [2:0] f3, input logic [7:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    drive(sel, wr, f3, addr, wd, 1'b1);
    @(posedge clk);
    #1 scramble(sel);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (sel ? rsp_valid_3 : rsp_valid_0) begin
        lat = n;
        break;
      end
    end
    rd = sel ? rsp_rdata_3 : rsp_rdata_0;
    er = sel ? rsp_err_3 : rsp_err_0;
    if (lat != 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transaction plus checks of latency, data and error flag.
  task automatic run(input string tag, input bit sel, input bit wr, input logic [2:0] f3,
                     input logic [7:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(sel, wr, f3, addr, wd, rd, er, lat);
    chk({tag, "_lat"}, 32'(lat), sel ? 32'd4 : 32'd1);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
  endtask

  logic [31:0] hold_rd;
  logic        hold_ok;
  int          lat;

  initial begin
    rst_0 = 1'b1; rst_3 = 1'b1;
    req_valid_0 = 1'b0; req_write_0 = 1'b0; req_funct3_0 = 3'd0; req_addr_0 = 8'd0;
    req_wdata_0 = 32'd0; rsp_ready_0 = 1'b1;
    req_valid_3 = 1'b0; req_write_3 = 1'b0; req_funct3_3 = 3'd0; req_addr_3 = 8'd0;
    req_wdata_3 = 32'd0; rsp_ready_3 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_0 = 1'b0; rst_3 = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready_0}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_0}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_0, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err_0}, 32'd0);

    // Zero latency: word store/load, then sub-word extension.
    run("sw10", 0, 1, 3'b010, 8'h10, 32'h8765_4321, 32'd0, 0);
    run("lw10", 0, 0, 3'b010, 8'h10, 32'd0, 32'h8765_4321, 0);
    run("lb13", 0, 0, 3'b000, 8'h13, 32'd0, 32'hFFFF_FF87, 0);
    run("lbu13", 0, 0, 3'b100, 8'h13, 32'd0, 32'h0000_0087, 0);
    run("lh12", 0, 0, 3'b001, 8'h12, 32'd0, 32'hFFFF_8765, 0);
    run("lhu12", 0, 0, 3'b101, 8'h12, 32'd0, 32'h0000_8765, 0);
    run("sb11", 0, 1, 3'b000, 8'h11, 32'h1234_56AA, 32'd0, 0);
    run("lw10b", 0, 0, 3'b010, 8'h10, 32'd0, 32'h8765_AA21, 0);
    run("sh14", 0, 1, 3'b001, 8'h14, 32'hCAFE_0102, 32'd0, 0);
    run("lw14", 0, 0, 3'b010, 8'h14, 32'd0, 32'h0000_0102, 0);

    // Misalignment.
    run("sw20", 0, 1, 3'b010, 8'h20, 32'h1122_3344, 32'd0, 0);
    run("sw22_mis", 0, 1, 3'b010, 8'h22, 32'h1234_5678, 32'd0, 1);
    run("lw20", 0, 0, 3'b010, 8'h20, 32'd0, 32'h1122_3344, 0);
    run("lh13_mis", 0, 0, 3'b001, 8'h13, 32'd0, 32'd0, 1);

    // Range and illegal funct3.
    run("lw40_oor", 0, 0, 3'b010, 8'h40, 32'd0, 32'd0, 1);
    run("sw3e_err", 0, 1, 3'b010, 8'h3E, 32'hFFFF_FFFF, 32'd0, 1);
    run("sh3e_ok", 0, 1, 3'b001, 8'h3E, 32'h0000_80C3, 32'd0, 0);
    run("lh3e", 0, 0, 3'b001, 8'h3E, 32'd0, 32'hFFFF_80C3, 0);
    run("lbu3f", 0, 0, 3'b100, 8'h3F, 32'd0, 32'h0000_0080, 0);
    run("f3_011", 0, 0, 3'b011, 8'h10, 32'd0, 32'd0, 1);
    run("st_f3_100", 0, 1, 3'b100, 8'h10, 32'h0000_0000, 32'd0, 1);
    run("lw10c", 0, 0, 3'b010, 8'h10, 32'd0, 32'h8765_AA21, 0);

    // Three wait states: backpressure on the response.
    run("l3_sw08", 1, 1, 3'b010, 8'h08, 32'h0BAD_F00D, 32'd0, 0);
    @(negedge clk);
    drive(1, 0, 3'b010, 8'h08, 32'd0, 1'b0);
    @(posedge clk);
    #1 scramble(1);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid_3) begin
        lat = n;
        break;
      end
    end
    chk("bp_lat", 32'(lat), 32'd4);
    chk("bp_rdata", rsp_rdata_3, 32'h0BAD_F00D);
    hold_rd = rsp_rdata_3;
    hold_ok = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (!rsp_valid_3 || req_ready_3 || rsp_err_3 || rsp_rdata_3 !== hold_rd) hold_ok = 1'b0;
    end
    chk("bp_hold", {31'd0, hold_ok}, 32'd1);
    rsp_ready_3 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_valid", {31'd0, rsp_valid_3}, 32'd0);
    chk("bp_rel_ready", {31'd0, req_ready_3}, 32'd1);

    // Reset one cycle after accepting a store: the store must be dropped.
    @(negedge clk);
    drive(1, 1, 3'b010, 8'h08, 32'hDEAD_BEEF, 1'b1);
    @(posedge clk);
    #1 scramble(1);
    @(negedge clk);
    rst_3 = 1'b1;
    @(negedge clk);
    rst_3 = 1'b0;
    chk("mid_rst_valid", {31'd0, rsp_valid_3}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready_3}, 32'd1);
    run("l3_lw08", 1, 0, 3'b010, 8'h08, 32'd0, 32'h0BAD_F00D, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
